// File: rtl/ram_dma_pkg.sv
// Shared definitions for the RAM block-transfer initiator and its bus interface.
package ram_dma_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic OP_COPY = 1'b0;
  localparam logic OP_FILL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_DONE
  } state_t;

  // Command captured when a start is accepted
  typedef struct packed {
    logic              op;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] len;
    logic [DATA_W-1:0] fill;
  } cmd_t;

  // Base plus offset, wrapping around the address space
  function automatic logic [ADDR_W-1:0] addr_off(input logic [ADDR_W-1:0] base,
                                                 input logic [ADDR_W-1:0] off);
    return ADDR_W'(base + off);
  endfunction

endpackage

// File: rtl/ram_dma_if.sv
// Command and RAM-pin bundle for ram_dma; master is the DMA, slave is the control/RAM side.
interface ram_dma_if;
  import ram_dma_pkg::*;

  // command side
  logic              start;
  logic              op;
  logic [ADDR_W-1:0] srcAddr;
  logic [ADDR_W-1:0] dstAddr;
  logic [ADDR_W-1:0] len;
  logic [DATA_W-1:0] fillByte;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] count;

  // RAM side
  logic              ramEnable;
  logic              ramReadWrite;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramDataIn;
  logic [DATA_W-1:0] ramDataOut;

  modport master (
    input  start, op, srcAddr, dstAddr, len, fillByte, ramDataOut,
    output busy, done, count, ramEnable, ramReadWrite, ramAddr, ramDataIn
  );

  modport slave (
    output start, op, srcAddr, dstAddr, len, fillByte, ramDataOut,
    input  busy, done, count, ramEnable, ramReadWrite, ramAddr, ramDataIn
  );

endinterface

// File: rtl/ram_dma.sv
// Block copy / fill engine driving a single-port synchronous RAM.
// Every output is a register loaded from the values for the state being entered,
// so the RAM sees each access in the cycle the FSM occupies the matching state.
module ram_dma
  import ram_dma_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  ram_dma_if.master bus
);

  state_t            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              en_q, en_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [ADDR_W-1:0] next_idx;

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.count        = count_q;
  assign bus.ramEnable    = en_q;
  assign bus.ramReadWrite = rw_q;
  assign bus.ramAddr      = addr_q;
  assign bus.ramDataIn    = din_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and next register values for outputs and the latched command
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    count_d  = count_q;
    en_d     = 1'b0;
    rw_d     = 1'b1;
    addr_d   = addr_q;
    din_d    = din_q;
    next_idx = ADDR_W'(count_q + ADDR_W'(1));

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          cmd_d.op   = bus.op;
          cmd_d.src  = bus.srcAddr;
          cmd_d.dst  = bus.dstAddr;
          cmd_d.len  = bus.len;
          cmd_d.fill = bus.fillByte;
          count_d    = '0;
          if (bus.len == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (bus.op == OP_FILL) begin
            state_d = ST_WR;
            busy_d  = 1'b1;
            en_d    = 1'b1;
            rw_d    = 1'b0;
            addr_d  = bus.dstAddr;
            din_d   = bus.fillByte;
          end else begin
            state_d = ST_RD;
            busy_d  = 1'b1;
            en_d    = 1'b1;
            addr_d  = bus.srcAddr;
          end
        end
      end

      ST_RD: begin
        state_d = ST_CAP;
        busy_d  = 1'b1;
      end

      // Read data is on ramDataOut now; the write-data register doubles as the byte latch
      ST_CAP: begin
        state_d = ST_WR;
        busy_d  = 1'b1;
        en_d    = 1'b1;
        rw_d    = 1'b0;
        addr_d  = addr_off(cmd_q.dst, count_q);
        din_d   = bus.ramDataOut;
      end

      ST_WR: begin
        count_d = next_idx;
        if (next_idx == cmd_q.len) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (cmd_q.op == OP_FILL) begin
          state_d = ST_WR;
          busy_d  = 1'b1;
          en_d    = 1'b1;
          rw_d    = 1'b0;
          addr_d  = addr_off(cmd_q.dst, next_idx);
          din_d   = cmd_q.fill;
        end else begin
          state_d = ST_RD;
          busy_d  = 1'b1;
          en_d    = 1'b1;
          addr_d  = addr_off(cmd_q.src, next_idx);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output, counter and command registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      en_q    <= 1'b0;
      rw_q    <= 1'b1;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      cmd_q   <= cmd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
      en_q    <= en_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

endmodule

// File: tb/tb_ram_dma.sv
// Bench for ram_dma: behavioural RAM on the bus, byte-array reference of memory contents.
module tb_ram_dma;
  import ram_dma_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_dma_if bus();

  ram_dma dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic        pl_we;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;

  // Synchronous single-port RAM with a preload port for the bench
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (bus.ramEnable) begin
      if (bus.ramReadWrite) bus.ramDataOut <= mem[bus.ramAddr];
      else                  mem[bus.ramAddr] <= bus.ramDataIn;
    end
  end

  // Count done pulses
  always @(posedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

  // Time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // Reference: bytes move in ascending order, addresses wrap at 64K
  task automatic ref_apply(input logic o, input logic [15:0] s, input logic [15:0] d,
                           input logic [15:0] l, input logic [7:0] f);
    for (int i = 0; i < int'(l); i++) begin
      if (o == OP_FILL) ref_mem[16'(d + 16'(i))] = f;
      else              ref_mem[16'(d + 16'(i))] = ref_mem[16'(s + 16'(i))];
    end
  endtask

  task automatic check_range(input string tag, input logic [15:0] base, input int n);
    logic [15:0] a;
    for (int k = 0; k < n; k++) begin
      a = 16'(base + 16'(k));
      chk($sformatf("%s[%04h]", tag, a), 32'(mem[a]), 32'(ref_mem[a]));
    end
  endtask

  // Issue one command, observe it to completion, then update the reference
  task automatic run_cmd(input logic o, input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] l, input logic [7:0] f, input int poke);
    int lat, en_cyc, rw_bad, exp_lat, exp_en;
    bit got;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.srcAddr = s; bus.dstAddr = d;
    bus.len = l; bus.fillByte = f;
    @(negedge clk);
    // scramble the inputs: the latched command must be unaffected
    bus.start = 1'b0; bus.op = ~o; bus.srcAddr = s ^ 16'h0F0F;
    bus.dstAddr = d ^ 16'h0F0F; bus.len = 16'(l + 16'd3); bus.fillByte = ~f;
    exp_lat = (l == 0) ? 1 : (o == OP_FILL) ? int'(l) + 1 : 3 * int'(l) + 1;
    exp_en  = (l == 0) ? 0 : (o == OP_FILL) ? int'(l) : 2 * int'(l);
    lat = -1; en_cyc = 0; rw_bad = 0; got = 1'b0;
    for (int k = 1; k <= 200 && !got; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 1) chk("busy_cycle1", 32'(bus.busy), 32'(l != 0));
      if (k == poke) begin
        bus.start = 1'b1; bus.op = OP_FILL; bus.dstAddr = 16'h0090;
        bus.len = 16'd2; bus.fillByte = 8'hEE;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.ramEnable === 1'b1) en_cyc++;
      else if (bus.ramReadWrite !== 1'b1) rw_bad++;
      if (bus.done === 1'b1) begin
        lat = k;
        got = 1'b1;
      end
    end
    bus.start = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("enable_cycles", 32'(en_cyc), 32'(exp_en));
    chk("readwrite_idle", 32'(rw_bad), 32'd0);
    chk("busy_at_done", 32'(bus.busy), 32'd0);
    chk("count_at_done", 32'(bus.count), 32'(l));
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("count_hold", 32'(bus.count), 32'(l));
    ref_apply(o, s, d, l, f);
  endtask

  initial begin
    logic        ro;
    logic [15:0] rs, rd, rl;
    logic [7:0]  rf;
    int          rp, d0;

    reset = 1'b1;
    bus.start = 1'b0; bus.op = 1'b0; bus.srcAddr = '0; bus.dstAddr = '0;
    bus.len = '0; bus.fillByte = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;

    // reset values
    #12;
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_en",    32'(bus.ramEnable), 32'd0);
    chk("rst_rw",    32'(bus.ramReadWrite), 32'd1);
    chk("rst_addr",  32'(bus.ramAddr), 32'd0);
    chk("rst_din",   32'(bus.ramDataIn), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // known contents for the windows used below
    for (int k = 0; k < 16'h0114; k++) preload(16'(16'hFFF0 + 16'(k)), 8'($urandom));
    for (int k = 0; k < 256; k++)      preload(16'(16'h0200 + 16'(k)), 8'($urandom));
    preload(16'h0000, 8'hAA);
    preload(16'h0001, 8'h01);
    preload(16'h0002, 8'h57);
    preload(16'h0020, 8'h11);
    preload(16'h0021, 8'h22);

    // fill
    run_cmd(OP_FILL, 16'h0000, 16'h0010, 16'd4, 8'hA5, 0);
    check_range("fill", 16'h000F, 6);
    chk("fill_0x13", 32'(mem[16'h0013]), 32'h0A5);

    // copy
    run_cmd(OP_COPY, 16'h0000, 16'h0100, 16'd3, 8'h00, 0);
    check_range("copy", 16'h00FF, 5);
    chk("copy_0x102", 32'(mem[16'h0102]), 32'h057);

    // wrap-around fill
    run_cmd(OP_FILL, 16'h0000, 16'hFFFE, 16'd4, 8'h3C, 0);
    check_range("wrap", 16'hFFFD, 6);
    chk("wrap_0x0001", 32'(mem[16'h0001]), 32'h03C);

    // zero length
    run_cmd(OP_FILL, 16'h0000, 16'h0050, 16'd0, 8'h99, 0);
    check_range("len0", 16'h0050, 1);

    // start while busy is ignored
    run_cmd(OP_COPY, 16'h0030, 16'h0080, 16'd4, 8'h00, 5);
    check_range("busystart", 16'h007F, 6);
    check_range("busystart_ignored", 16'h0090, 2);

    // overlapping forward copy propagates
    run_cmd(OP_COPY, 16'h0020, 16'h0021, 16'd2, 8'h00, 0);
    check_range("overlap", 16'h001F, 5);
    chk("overlap_0x22", 32'(mem[16'h0022]), 32'h011);

    // reset during the third write of an 8-byte fill
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_FILL; bus.dstAddr = 16'h0040;
    bus.len = 16'd8; bus.fillByte = 8'h77;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("en_before_reset", 32'(bus.ramEnable), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("reset_en",    32'(bus.ramEnable), 32'd0);
    chk("reset_busy",  32'(bus.busy), 32'd0);
    chk("reset_count", 32'(bus.count), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_no_done", 32'(done_cnt - d0), 32'd0);
    ref_apply(OP_FILL, 16'h0000, 16'h0040, 16'd2, 8'h77);
    check_range("reset_fill", 16'h003F, 10);

    // randomized commands
    for (int r = 0; r < 24; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        rs = 16'(16'hFFF0 + 16'($urandom_range(0, 15)));
        rd = 16'(16'hFFF8 + 16'($urandom_range(0, 7)));
      end else begin
        rs = 16'(16'h0200 + 16'($urandom_range(1, 200)));
        rd = 16'(16'h0200 + 16'($urandom_range(1, 200)));
      end
      rl = 16'($urandom_range(0, 12));
      ro = 1'($urandom_range(0, 1));
      rf = 8'($urandom);
      rp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 10)) : 0;
      run_cmd(ro, rs, rd, rl, rf, rp);
      check_range($sformatf("rand%0d", r), 16'(rd - 16'd1), int'(rl) + 2);
    end

    // whole known windows against the reference
    check_range("final_lo", 16'hFFF0, 16'h0114);
    check_range("final_hi", 16'h0200, 256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_dma.md
# ram_dma

Block-transfer initiator for the 64 KB single-port RAM: it owns the RAM's enable/readWrite/addr/dataIn pins and drives them to copy a run of bytes from one address range to another, or to fill a range with a constant byte. It sits between a control source (CPU-side register block or testbench) and the `ram64kb` instance, replacing hand-driven RAM stimulus with a command-level interface.

## Interface

- `ADDR_W`, 16, RAM address width; the address space is 2^ADDR_W bytes.
- `DATA_W`, 8, RAM data width.

- `clk`  in  1  rising-edge clock, shared with the RAM.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `op`  in  1  0 = copy, 1 = fill.
- `srcAddr`  in  ADDR_W  copy source base address; ignored for fill.
- `dstAddr`  in  ADDR_W  destination base address.
- `len`  in  ADDR_W  byte count; 0 means no transfer.
- `fillByte`  in  DATA_W  fill value.
- `busy`  out  1  high from the cycle after an accepted start until `done`.
- `done`  out  1  one-cycle completion pulse.
- `count`  out  ADDR_W  bytes written so far in the current command.
- `ramEnable`  out  1  to RAM enable.
- `ramReadWrite`  out  1  to RAM readWrite: 1 = read, 0 = write.
- `ramAddr`  out  ADDR_W  to RAM addr.
- `ramDataIn`  out  DATA_W  to RAM dataIn.
- `ramDataOut`  in  DATA_W  from RAM dataOut.

## Operation

- RAM contract: the RAM samples enable/readWrite/addr/dataIn on the rising edge; with enable=0 the RAM neither reads nor writes; read data is valid on `ramDataOut` in the cycle after the read access is presented.
- Command latch: in IDLE, `start`=1 at a rising edge latches `op`, `srcAddr`, `dstAddr`, `len`, and `fillByte`; later changes to the inputs have no effect until the next IDLE.
- States: IDLE, RD, CAP, WR, DONE.
  - IDLE: `start` & `len`≠0 → RD (copy) or WR (fill); `start` & `len`=0 → DONE.
  - RD: drive ramEnable=1, ramReadWrite=1, ramAddr=src+i → CAP.
  - CAP: ramEnable=0; register `ramDataOut` into the data latch → WR.
  - WR: drive ramEnable=1, ramReadWrite=0, ramAddr=dst+i, ramDataIn=latch (copy) or fillByte (fill); increment i and `count`. If i+1=len → DONE, else RD (copy) or WR (fill).
  - DONE: `done`=1 for one cycle, `busy`=0 → IDLE.
- Address arithmetic: src+i and dst+i are computed modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000.
- Overlap: bytes are copied in strictly ascending order. If dst is in (src, src+len), the copy propagates already-written bytes, and this is the required behaviour.
- `start` while busy: ignored, with no queuing.
- In every state other than RD and WR, ramEnable=0. ramReadWrite idles at 1, so that no spurious write occurs.

## Timing

- Reset values: busy=0, done=0, count=0, ramEnable=0, ramReadWrite=1, ramAddr=0, ramDataIn=0, state=IDLE. Reset is asynchronous, so ramEnable drops in the same instant reset asserts.
- Reset mid-transfer aborts the transfer: bytes already written stay written, no `done` is produced, and `count` returns to 0.
- The first RAM access occurs in the cycle after start is accepted.
- Copy of N bytes: 3N cycles of RAM activity, with `done` in cycle 3N+1 after acceptance.
- Fill of N bytes: N cycles, with `done` in cycle N+1.
- len=0: `done` in cycle 1 after acceptance, with no RAM access.
- `count` updates on the edge that commits each write. `count` holds its final value after `done` until the next accepted start, which clears it.
- All outputs are registered. No combinational path runs from `ramDataOut` to any output.

## Structure

- Shared package: state encoding (IDLE/RD/CAP/WR/DONE), the op codes OP_COPY=0 and OP_FILL=1, and the ADDR_W/DATA_W defaults shared with `ram64kb`.
- Single module; no sub-module is needed.
- Integration bench: `ram_dma` wired directly to a `ram64kb` instance, with a backdoor-free check by reading back through `ram_dma` copies or direct RAM reads after `done`.

## Test plan

- Fill: op=1, dst=0x0010, len=4, fillByte=0xA5. Required: 0x10–0x13 read 0xA5 and 0x14 is unchanged; `done` arrives 5 cycles after start; count=4.
- Copy: preload 0x0000–0x0002 = 0xAA, 0x01, 0x57, then copy src=0x0000, dst=0x0100, len=3. Required: 0x100–0x102 = 0xAA, 0x01, 0x57; `done` arrives 10 cycles after start.
- Wrap: fill dst=0xFFFE, len=4, fillByte=0x3C. Required: 0xFFFE, 0xFFFF, 0x0000, and 0x0001 all read 0x3C.
- len=0 and busy-start: len=0 gives `done` 1 cycle after start with ramEnable never high. A second `start` pulse mid-copy is ignored, and the original copy completes unchanged.
- Overlap: 0x20=0x11, 0x21=0x22; copy src=0x20, dst=0x21, len=2. Required: 0x21=0x11 and 0x22=0x11.
- Reset mid-fill: assert reset during the 3rd WR of an 8-byte fill. Required: ramEnable=0 immediately, busy=0, count=0, no `done` pulse, and only the first two bytes are written.
